// File: rtl/pin_group_arbiter_pkg.sv
// Shared types and defaults for the pin-group arbiter: FSM state encoding,
// default sizing constants and an index-width helper.
package pin_group_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OWNED      = 2'd1,
    TURNAROUND = 2'd2
  } pin_arb_state_e;

  localparam int unsigned PinArbNumReq     = 4;
  localparam int unsigned PinArbPinWidth   = 8;
  localparam int unsigned PinArbTurnaround = 4;

  // Keeps index vectors at least one bit wide for degenerate requester counts.
  function automatic int unsigned pin_arb_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pin_group_arbiter_if.sv
// Bundle between the requesting peripherals / pin buffers and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric.
interface pin_group_arbiter_if
  import pin_group_arbiter_pkg::*;
#(
  parameter int unsigned NumReq   = PinArbNumReq,
  parameter int unsigned PinWidth = PinArbPinWidth
);

  localparam int unsigned IdxW = pin_arb_idx_w(NumReq);

  logic [NumReq-1:0]                req_i;
  logic [NumReq-1:0]                grant_o;
  logic [NumReq-1:0][PinWidth-1:0]  req_pin_i;
  logic [NumReq-1:0][PinWidth-1:0]  req_pin_en_i;
  logic [NumReq-1:0][PinWidth-1:0]  req_pin_o;
  logic [PinWidth-1:0]              pin_o;
  logic [PinWidth-1:0]              pin_en_o;
  logic [PinWidth-1:0]              pin_i;
  logic [IdxW-1:0]                  owner_o;
  logic                             busy_o;

  modport slave (
    input  req_i, req_pin_i, req_pin_en_i, pin_i,
    output grant_o, req_pin_o, pin_o, pin_en_o, owner_o, busy_o
  );

  modport master (
    output req_i, req_pin_i, req_pin_en_i, pin_i,
    input  grant_o, req_pin_o, pin_o, pin_en_o, owner_o, busy_o
  );

endinterface

// File: rtl/pin_group_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible request at or after the
// pointer; excluded requesters lose unless nobody else is asking.
module pin_group_arbiter_rr_pick
  import pin_group_arbiter_pkg::*;
#(
  parameter int unsigned NumReq = PinArbNumReq,
  localparam int unsigned IdxW  = pin_arb_idx_w(NumReq)
) (
  input  logic [NumReq-1:0] i_req,
  input  logic [IdxW-1:0]   i_ptr,
  input  logic [NumReq-1:0] i_excl,
  output logic [NumReq-1:0] o_onehot,
  output logic [IdxW-1:0]   o_idx,
  output logic              o_valid
);

  logic [NumReq-1:0] w_masked;
  logic [NumReq-1:0] w_elig;
  logic [IdxW-1:0]   w_k;

  always_comb begin
    w_masked = i_req & ~i_excl;
    w_elig   = (|w_masked) ? w_masked : i_req;
    o_onehot = '0;
    o_idx    = '0;
    o_valid  = 1'b0;
    w_k      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      w_k = IdxW'((32'(i_ptr) + i) % NumReq);
      if (!o_valid && w_elig[w_k]) begin
        o_valid     = 1'b1;
        o_idx       = w_k;
        o_onehot[w_k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pin_group_arbiter.sv
// Round-robin owner of a shared header-pin group, with a tri-state turnaround
// window on every hand-over and an optional tenure limit while others wait.
module pin_group_arbiter
  import pin_group_arbiter_pkg::*;
#(
  parameter int unsigned NumReq           = PinArbNumReq,
  parameter int unsigned PinWidth         = PinArbPinWidth,
  parameter int unsigned TurnaroundCycles = PinArbTurnaround,
  parameter int unsigned MaxHoldCycles    = 0
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_ni,
  pin_group_arbiter_if.slave  arb
);

  localparam int unsigned IdxW   = pin_arb_idx_w(NumReq);
  localparam int unsigned TcntW  = $clog2(TurnaroundCycles + 1);
  localparam int unsigned HoldW  = (MaxHoldCycles > 0) ? $clog2(MaxHoldCycles + 1) : 1;
  localparam bit          HoldEn = (MaxHoldCycles > 0);

  pin_arb_state_e    r_state, w_state_d;
  logic [IdxW-1:0]   r_owner, w_owner_d;
  logic [NumReq-1:0] r_grant, w_grant_d;
  logic [IdxW-1:0]   r_ptr,   w_ptr_d;
  logic [TcntW-1:0]  r_tcnt,  w_tcnt_d;
  logic [HoldW-1:0]  r_hold,  w_hold_d;
  logic [NumReq-1:0] r_excl,  w_excl_d;

  logic [NumReq-1:0] w_pick_onehot;
  logic [IdxW-1:0]   w_pick_idx;
  logic              w_pick_valid;
  logic              w_take;
  logic              w_owner_req;
  logic              w_others;
  logic              w_hold_hit;

  pin_group_arbiter_rr_pick #(
    .NumReq (NumReq)
  ) u_pick (
    .i_req    (arb.req_i),
    .i_ptr    (r_ptr),
    .i_excl   (r_excl),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  assign w_owner_req = arb.req_i[r_owner];
  assign w_others    = |(arb.req_i & ~r_grant);
  assign w_hold_hit  = (32'(r_hold) + 32'd1) >= MaxHoldCycles;

  always_ff @(posedge clk_sys_i) begin
    if (!rst_sys_ni) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
      r_tcnt  <= '0;
      r_hold  <= '0;
      r_excl  <= '0;
    end else begin
      r_state <= w_state_d;
      r_owner <= w_owner_d;
      r_grant <= w_grant_d;
      r_ptr   <= w_ptr_d;
      r_tcnt  <= w_tcnt_d;
      r_hold  <= w_hold_d;
      r_excl  <= w_excl_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_owner_d = r_owner;
    w_grant_d = r_grant;
    w_ptr_d   = r_ptr;
    w_tcnt_d  = r_tcnt;
    w_hold_d  = r_hold;
    w_excl_d  = r_excl;
    w_take    = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_take = w_pick_valid;
      end
      OWNED: begin
        // A simultaneous release and revoke resolves as a plain release.
        if (!w_owner_req || (HoldEn && w_others && w_hold_hit)) begin
          w_state_d = TURNAROUND;
          w_grant_d = '0;
          w_owner_d = '0;
          w_tcnt_d  = TcntW'(TurnaroundCycles - 1);
          w_excl_d  = w_owner_req ? r_grant : '0;
        end else if (HoldEn && w_others) begin
          w_hold_d = r_hold + 1'b1;
        end
      end
      TURNAROUND: begin
        if (r_tcnt == '0) begin
          w_excl_d = '0;
          if (w_pick_valid) begin
            w_take = 1'b1;
          end else begin
            w_state_d = IDLE;
          end
        end else begin
          w_tcnt_d = r_tcnt - 1'b1;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase

    if (w_take) begin
      w_state_d = OWNED;
      w_owner_d = w_pick_idx;
      w_grant_d = w_pick_onehot;
      w_ptr_d   = (w_pick_idx == IdxW'(NumReq - 1)) ? '0 : w_pick_idx + 1'b1;
      w_hold_d  = '0;
      w_excl_d  = '0;
    end
  end

  always_comb begin
    arb.pin_o     = '0;
    arb.pin_en_o  = '0;
    arb.req_pin_o = '0;
    if (r_state == OWNED) begin
      arb.pin_o              = arb.req_pin_i[r_owner];
      arb.pin_en_o           = arb.req_pin_en_i[r_owner];
      arb.req_pin_o[r_owner] = arb.pin_i;
    end
  end

  assign arb.grant_o = r_grant;
  assign arb.owner_o = r_owner;
  assign arb.busy_o  = (r_state != IDLE);

endmodule

// File: tb/tb_pin_group_arbiter.sv
// Directed bench for pin_group_arbiter: 4 requesters, 8 pins, turnaround 4,
// tenure limit 10.
module tb_pin_group_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  pin_group_arbiter_if #(.NumReq(4), .PinWidth(8)) arb ();

  pin_group_arbiter #(
    .NumReq           (4),
    .PinWidth         (8),
    .TurnaroundCycles (4),
    .MaxHoldCycles    (10)
  ) u_dut (
    .clk_sys_i  (clk),
    .rst_sys_ni (rst_n),
    .arb        (arb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] pins_v [4];
  logic [7:0] ens_v  [4];
  logic [7:0] pin_in_v;

  logic [54:0] obs;
  assign obs = {arb.grant_o, arb.owner_o, arb.busy_o, arb.pin_o, arb.pin_en_o, arb.req_pin_o};

  function automatic logic [54:0] exp_vec(input int k, input logic busy);
    logic [3:0]  g;
    logic [1:0]  o;
    logic [7:0]  p;
    logic [7:0]  e;
    logic [31:0] rp;
    logic [1:0]  kk;
    g = '0; o = '0; p = '0; e = '0; rp = '0;
    if (k >= 0) begin
      kk = 2'(k);
      g  = 4'b0001 << kk;
      o  = kk;
      p  = pins_v[kk];
      e  = ens_v[kk];
      rp = 32'(pin_in_v) << (8 * kk);
    end
    return {g, o, busy, p, e, rp};
  endfunction

  task automatic drive_pins();
    for (int k = 0; k < 4; k++) begin
      arb.req_pin_i[k]    = pins_v[k];
      arb.req_pin_en_i[k] = ens_v[k];
    end
    arb.pin_i = pin_in_v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    arb.req_i = 4'b1111;
    drive_pins();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (obs !== exp_vec(-1, 1'b0)) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got=%h want=%h", i, obs, exp_vec(-1, 1'b0));
      end
    end
    arb.req_i = 4'b0000;
    rst_n     = 1'b1;
    tick();
    n_tests++;
    if (obs !== exp_vec(-1, 1'b0)) begin
      n_fail++;
      $display("FAIL idle_after_reset got=%h want=%h", obs, exp_vec(-1, 1'b0));
    end
  endtask

  task automatic test_grant_latency();
    arb.req_i = 4'b0001;
    #1;
    n_tests++;
    if (obs !== exp_vec(-1, 1'b0)) begin
      n_fail++;
      $display("FAIL no_grant_before_edge got=%h want=%h", obs, exp_vec(-1, 1'b0));
    end
    tick();
    n_tests++;
    if (obs !== exp_vec(0, 1'b1)) begin
      n_fail++;
      $display("FAIL grant_latency got=%h want=%h", obs, exp_vec(0, 1'b1));
    end
  endtask

  task automatic test_release();
    arb.req_i = 4'b0111;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++;
      if (obs !== exp_vec(0, 1'b1)) begin
        n_fail++;
        $display("FAIL hold_owner0 cyc=%0d got=%h want=%h", i, obs, exp_vec(0, 1'b1));
      end
    end
    arb.req_i = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (obs !== exp_vec(-1, 1'b1)) begin
        n_fail++;
        $display("FAIL release_turnaround cyc=%0d got=%h want=%h", i, obs, exp_vec(-1, 1'b1));
      end
    end
    tick();
    n_tests++;
    if (obs !== exp_vec(1, 1'b1)) begin
      n_fail++;
      $display("FAIL next_grant_rr got=%h want=%h", obs, exp_vec(1, 1'b1));
    end
    arb.req_i = 4'b0100;
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (obs !== exp_vec(-1, 1'b1)) begin
      n_fail++;
      $display("FAIL turnaround_last_cycle got=%h want=%h", obs, exp_vec(-1, 1'b1));
    end
    tick();
    n_tests++;
    if (obs !== exp_vec(2, 1'b1)) begin
      n_fail++;
      $display("FAIL grant_owner2 got=%h want=%h", obs, exp_vec(2, 1'b1));
    end
    arb.req_i = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (obs !== exp_vec(-1, 1'b0)) begin
      n_fail++;
      $display("FAIL back_to_idle got=%h want=%h", obs, exp_vec(-1, 1'b0));
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    rst_n     = 1'b0;
    arb.req_i = 4'b0000;
    tick();
    rst_n     = 1'b1;
    arb.req_i = 4'b1111;
    tick();
    for (int s = 0; s < 5; s++) begin
      for (int j = 0; j < 3; j++) begin
        if (j > 0) tick();
        n_tests++;
        if (obs !== exp_vec(order[s], 1'b1)) begin
          n_fail++;
          $display("FAIL rr_owner slot=%0d cyc=%0d got=%h want=%h", s, j, obs, exp_vec(order[s], 1'b1));
        end
      end
      arb.req_i = 4'b1111 & ~(4'b0001 << order[s]);
      for (int j = 0; j < 4; j++) begin
        tick();
        n_tests++;
        if (obs !== exp_vec(-1, 1'b1)) begin
          n_fail++;
          $display("FAIL rr_turnaround slot=%0d cyc=%0d got=%h want=%h", s, j, obs, exp_vec(-1, 1'b1));
        end
      end
      arb.req_i = 4'b1111;
      tick();
    end
  endtask

  task automatic test_revoke();
    rst_n     = 1'b0;
    arb.req_i = 4'b0000;
    tick();
    rst_n     = 1'b1;
    arb.req_i = 4'b0001;
    tick();
    arb.req_i = 4'b1101;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_tests++;
      if (obs !== exp_vec(0, 1'b1)) begin
        n_fail++;
        $display("FAIL revoke_hold cyc=%0d got=%h want=%h", i, obs, exp_vec(0, 1'b1));
      end
    end
    tick();
    n_tests++;
    if (obs !== exp_vec(-1, 1'b1)) begin
      n_fail++;
      $display("FAIL revoke_cut got=%h want=%h", obs, exp_vec(-1, 1'b1));
    end
    for (int i = 0; i < 3; i++) tick();
    tick();
    n_tests++;
    if (obs !== exp_vec(2, 1'b1)) begin
      n_fail++;
      $display("FAIL revoke_next got=%h want=%h", obs, exp_vec(2, 1'b1));
    end
    arb.req_i = 4'b1001;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (obs !== exp_vec(3, 1'b1)) begin
      n_fail++;
      $display("FAIL revoke_then_owner3 got=%h want=%h", obs, exp_vec(3, 1'b1));
    end
    arb.req_i = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (obs !== exp_vec(0, 1'b1)) begin
      n_fail++;
      $display("FAIL revoke_owner0_regrant got=%h want=%h", obs, exp_vec(0, 1'b1));
    end
    // Revoked owner is the only one left asking by the decision edge.
    arb.req_i = 4'b0011;
    for (int i = 0; i < 10; i++) tick();
    n_tests++;
    if (obs !== exp_vec(-1, 1'b1)) begin
      n_fail++;
      $display("FAIL revoke_sole_cut got=%h want=%h", obs, exp_vec(-1, 1'b1));
    end
    arb.req_i = 4'b0001;
    for (int i = 0; i < 4; i++) tick();
    n_tests++;
    if (obs !== exp_vec(0, 1'b1)) begin
      n_fail++;
      $display("FAIL revoke_sole_regrant got=%h want=%h", obs, exp_vec(0, 1'b1));
    end
  endtask

  task automatic test_reset_mid_turnaround();
    arb.req_i = 4'b0000;
    tick();
    tick();
    n_tests++;
    if (obs !== exp_vec(-1, 1'b1)) begin
      n_fail++;
      $display("FAIL in_turnaround got=%h want=%h", obs, exp_vec(-1, 1'b1));
    end
    rst_n     = 1'b0;
    arb.req_i = 4'b1111;
    tick();
    n_tests++;
    if (obs !== exp_vec(-1, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_mid_turnaround got=%h want=%h", obs, exp_vec(-1, 1'b0));
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (obs !== exp_vec(0, 1'b1)) begin
      n_fail++;
      $display("FAIL post_reset_first_grant got=%h want=%h", obs, exp_vec(0, 1'b1));
    end
  endtask

  task automatic test_nonowner_isolation();
    ens_v[1] = 8'hFF;
    pin_in_v = 8'hFF;
    drive_pins();
    #1;
    n_tests++;
    if (obs !== exp_vec(0, 1'b1)) begin
      n_fail++;
      $display("FAIL nonowner_isolation got=%h want=%h", obs, exp_vec(0, 1'b1));
    end
    n_tests++;
    if (arb.req_pin_o[1] !== 8'h00) begin
      n_fail++;
      $display("FAIL nonowner_req_pin_o got=%h want=00", arb.req_pin_o[1]);
    end
    tick();
    n_tests++;
    if (arb.pin_en_o !== 8'h0F) begin
      n_fail++;
      $display("FAIL nonowner_pin_en got=%h want=0f", arb.pin_en_o);
    end
  endtask

  initial begin
    pins_v    = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    ens_v     = '{8'h0F, 8'hF0, 8'h3C, 8'hC3};
    pin_in_v  = 8'h5A;
    rst_n     = 1'b0;
    arb.req_i = '0;
    drive_pins();

    test_reset();
    test_grant_latency();
    test_release();
    test_round_robin();
    test_revoke();
    test_reset_mid_turnaround();
    test_nonowner_isolation();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pin_group_arbiter.md
# pin_group_arbiter

Shares one group of header pins (e.g. the R-Pi SPI0 group) between several on-chip requesters (SPI host, GPIO, bit-bang debug). It grants the group to one requester at a time using round-robin. On every hand-over it inserts a tri-state turnaround window so two drivers never fight on a pin. It sits between the peripherals and the top-level pin buffers, and drives the pin output/enable vectors those buffers consume.

## Interface
- NumReq, 4, number of requesters (2..8)
- PinWidth, 8, pins in the shared group
- TurnaroundCycles, 4, cycles all enables are held low between owners (≥1)
- MaxHoldCycles, 0, grant-tenure limit while others wait; 0 = unlimited
- Clock and reset: one clock; reset is synchronous and active-low.
- clk_sys_i  in  1  system clock
- rst_sys_ni  in  1  synchronous active-low reset
- req_i  in  NumReq  level request; held high for the whole tenure, dropped to release
- grant_o  out  NumReq  one-hot grant, registered
- req_pin_i  in  NumReq×PinWidth  per-requester pin output values
- req_pin_en_i  in  NumReq×PinWidth  per-requester pin output enables
- req_pin_o  out  NumReq×PinWidth  pin input values; owner sees pin_i, others see 0
- pin_o  out  PinWidth  value to pin buffer
- pin_en_o  out  PinWidth  enable to pin buffer
- pin_i  in  PinWidth  value from pin buffer
- owner_o  out  $clog2(NumReq)  index of current owner
- busy_o  out  1  high in OWNED or TURNAROUND

## Operation
- States:
  - IDLE: no owner, all enables low. Any req_i → OWNED(winner) at the next edge.
  - OWNED: the owner's pins pass through. The owner drops req_i → TURNAROUND. The hold limit expires → TURNAROUND (revoke).
  - TURNAROUND: all enables low and grant_o = 0. The counter counts down. On its last cycle:
    - arbitrate again; any req → OWNED(winner);
    - no req → IDLE.
- Round-robin: the search starts at (last owner + 1) mod NumReq. The pointer updates only on a grant. After reset the pointer sits so that index 0 has highest priority.
- Revoke: applies when MaxHoldCycles > 0 and another req_i is high. A hold counter counts owner cycles only while someone else waits, and resets on each new grant. When it reaches MaxHoldCycles, the grant is revoked.
  - A revoked owner that keeps req_i high is not preferred; round-robin excludes it in the next decision unless it is the only requester.
- If release and revoke occur in the same cycle, treat it as a release; the result is identical.
- Muxing:
  - pin_o and pin_en_o come combinationally from the owner's req_pin_i/req_pin_en_i, selected by the registered owner, gated by state == OWNED.
  - Non-owners' req_pin_i/req_pin_en_i are ignored.
- req_pin_o: the owner's slot = pin_i; every other slot = 0. In IDLE and TURNAROUND all slots are 0.
- Reset (any cycle, including mid-tenure or mid-turnaround) → IDLE. All registers clear, so every output reads 0: grant_o, owner_o, busy_o, pin_en_o, pin_o and req_pin_o.

## Timing
- Grant latency: req_i high in IDLE at cycle n → grant_o and pin enables live at cycle n+1.
- Release: owner req_i low at cycle n → grant_o and pin_en_o low from cycle n+1. They stay low for exactly TurnaroundCycles cycles (n+1 .. n+T). The earliest next grant is at cycle n+T+1.
- Revoke: the counter hits MaxHoldCycles at cycle n → grant_o low at n+1, followed by the same turnaround.
- A req_i pulse shorter than one cycle that is not sampled high at an edge is never granted.
- grant_o never has two bits set. It is never set during TURNAROUND.

## Structure
- sonata_pkg gets:
  - pin_arb_state_e (IDLE, OWNED, TURNAROUND);
  - default constants PinArbTurnaround and PinArbNumReq.
- Sub-module pin_arb_rr_pick: combinational round-robin picker. It takes the request vector, the pointer and an exclude mask, and returns a one-hot winner, its index and a valid flag.
- Top-level integration:
  - pin_o/pin_en_o feed the group's slots in the output/inout pin vectors;
  - pin_i comes from the inout-from-pins vector.

## Test plan
- Reset, then req_i=0001 at cycle 5 → grant_o=0001 and pin_en_o=req_pin_en_i[0] at cycle 6; all outputs 0 during reset.
- Owner 0 releases at cycle 20 with req_i=0110 pending, T=4 → pin_en_o=0 for cycles 21–24, grant_o=0010 at cycle 25.
- All four requesting continuously, each releases after 3 cycles of tenure → grant order 0,1,2,3,0; grant_o is one-hot throughout.
- MaxHoldCycles=10, req 0 held with req 2 waiting → revoke after 10 waiting cycles, grant_o=0100 after turnaround; req 0 re-granted only after 2 releases.
- Reset asserted mid-turnaround → the next cycle shows IDLE with all outputs 0; after reset the first grant goes to index 0 when 1111 is requested.
- Non-owner drives req_pin_en_i all-ones → pin_en_o is unaffected; the non-owner's req_pin_o reads 0 while pin_i=0xFF.
